// File: rtl/sqrt_pkg.sv
// Shared definitions for the round-robin square-root scheduler.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TEST   = 2'b01,
    UPDATE = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/sqrt_rr_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr, and ptr moves past each winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] ptr;
  logic           found;
  int             idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      ptr <= '0;
    else if (advance)
      ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Shares one odd-number-subtraction square-root engine among NREQ requesters.
// state  | meaning
// IDLE   | arbitrate and accept one operand
// TEST   | compare sq against a
// UPDATE | sq += del, del += 2
// DONE   | hold the tagged result until rsp_ready
module sqrt_rr_scheduler
  import sqrt_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH/2-1:0]    rsp_root,
  input  logic                  rsp_ready,
  output logic                  busy
);

  localparam int DW = WIDTH / 2 + 2;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH:0]   sq;
  logic [DW-1:0]    del;
  logic [IDW-1:0]   id;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             idle;
  logic             xfer;
  logic [WIDTH/2:0] root_full;

  // Requests are masked while clr is high so req_ready is quiet during reset.
  assign idle      = (state == IDLE) && !clr;
  assign req_ready = grant;
  assign xfer      = |grant;
  assign busy      = (state != IDLE);
  assign root_full = del[DW-1:1] - 1'b1;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .clr       (clr),
    .req       (req_valid & {NREQ{idle}}),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      a         <= '0;
      sq        <= '0;
      del       <= '0;
      id        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_root  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            a     <= req_data[grant_idx*WIDTH +: WIDTH];
            sq    <= (WIDTH+1)'(1);
            del   <= DW'(3);
            id    <= grant_idx;
            state <= TEST;
          end
        end
        TEST: begin
          if (sq <= {1'b0, a}) begin
            state <= UPDATE;
          end else begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_root  <= root_full[WIDTH/2-1:0];
          end
        end
        UPDATE: begin
          sq    <= sq + (WIDTH+1)'(del);
          del   <= del + DW'(2);
          state <= TEST;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
